tile_seq_ctrl: RTL and testbench

Sequencer that feeds the 8×16 byte-tile datapath (tile array in, 16-bit config word, start strobe; tile array out, done flag). It collects a tile from an upstream byte stream into a local buffer, latches a config word, starts the datapath, waits for completion with a timeout, captures the result tile, and streams it out row-major. It sits between the system stream fabric and one datapath instance.

---
 rtl/tile_seq_pkg.sv | 20 ++
 rtl/tile_rc_cnt.sv | 39 +++
 rtl/tile_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_tile_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_seq_pkg.sv
// Shared geometry, state encoding and tile type for the tile sequencer.
package tile_seq_pkg;
    localparam int ROWS   = 8;
    localparam int COLS   = 16;
    localparam int DATA_W = 8;
    localparam int CFG_W  = 16;
    localparam int NELEM  = ROWS * COLS;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_DRAIN
    } tile_seq_state_e;

    typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] tile_t;
endpackage

// File: rtl/tile_rc_cnt.sv
// Row-major row/col index counter; saturates at the last element so it never
// wraps inside a tile. Clear wins over increment.
module tile_rc_cnt
    import tile_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last
);
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_row_end;

    assign w_row_end = (r_col == CW'(COLS - 1));
    assign o_last    = w_row_end && (r_row == RW'(ROWS - 1));
    assign o_row     = r_row;
    assign o_col     = r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc && !o_last) begin
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tile_seq_ctrl.sv
// Sequencer: stream a tile in, launch the datapath, wait with timeout,
// capture the result and stream it out row-major.
module tile_seq_ctrl
    import tile_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid,
    input  logic [CFG_W-1:0]                       cfg_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_W-1:0]                      s_data,
    input  logic                                   s_last,
    output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  dp_tile,
    output logic [CFG_W-1:0]                       dp_cfg,
    output logic                                   dp_start,
    input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  dp_result,
    input  logic                                   dp_done,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_W-1:0]                      m_data,
    output logic                                   m_last,
    output logic                                   busy,
    output logic                                   err_len,
    output logic                                   err_timeout,
    input  logic                                   err_clr
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    tile_seq_state_e  r_state;
    tile_t            r_tile;
    tile_t            r_res;
    logic [CFG_W-1:0] r_cfg;
    logic             r_dp_start;
    logic             r_err_len;
    logic             r_err_tmo;
    logic [TW-1:0]    r_tcnt;

    logic [RW-1:0] w_ld_row, w_dr_row;
    logic [CW-1:0] w_ld_col, w_dr_col;
    logic          w_ld_last, w_dr_last;
    logic          w_in_phase, w_s_hs, w_take, w_to_run, w_len_set;
    logic          w_done, w_tmo, w_tmo_set, w_m_hs, w_to_idle;

    // s_ready is held low while reset is asserted, high right after release.
    assign w_in_phase = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign s_ready    = rst_n && w_in_phase;
    assign w_s_hs     = s_valid && s_ready;
    assign w_take     = w_s_hs && (r_state != S_FLUSH);
    assign w_to_run   = w_s_hs && s_last;
    assign w_len_set  = w_take && (s_last ? !w_ld_last : w_ld_last);

    // The start cycle itself never samples dp_done.
    assign w_done     = (r_state == S_RUN) && !r_dp_start && dp_done;
    assign w_tmo      = (TIMEOUT_CYC != 0) && (r_tcnt == TW'(TIMEOUT_CYC));
    assign w_tmo_set  = (r_state == S_RUN) && !w_done && w_tmo;
    assign w_m_hs     = m_valid && m_ready;
    assign w_to_idle  = w_tmo_set || (w_m_hs && w_dr_last);

    tile_rc_cnt u_ld_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_to_idle),
        .i_inc  (w_take),
        .o_row  (w_ld_row),
        .o_col  (w_ld_col),
        .o_last (w_ld_last)
    );

    tile_rc_cnt u_dr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_to_idle),
        .i_inc  (w_m_hs),
        .o_row  (w_dr_row),
        .o_col  (w_dr_col),
        .o_last (w_dr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tile     <= '0;
            r_res      <= '0;
            r_cfg      <= '0;
            r_dp_start <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_dp_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) r_cfg <= cfg_data;
                    // Clearing the whole buffer here leaves a short tile zero-padded.
                    if (w_s_hs) begin
                        r_tile       <= '0;
                        r_tile[0][0] <= s_data;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_s_hs) begin
                        r_tile[w_ld_row][w_ld_col] <= s_data;
                        if (w_ld_last && !s_last) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                end
                S_RUN: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_done) begin
                        r_res   <= dp_result;
                        r_state <= S_DRAIN;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_m_hs && w_dr_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // An accepted s_last in any input state ends the tile.
            if (w_to_run) begin
                r_state    <= S_RUN;
                r_dp_start <= 1'b1;
                r_tcnt     <= TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len <= 1'b0;
            r_err_tmo <= 1'b0;
        end else begin
            r_err_len <= w_len_set || (r_err_len && !err_clr);
            r_err_tmo <= w_tmo_set || (r_err_tmo && !err_clr);
        end
    end

    assign dp_tile     = r_tile;
    assign dp_cfg      = r_cfg;
    assign dp_start    = r_dp_start;
    assign busy        = (r_state != S_IDLE);
    assign m_valid     = (r_state == S_DRAIN);
    assign m_data      = m_valid ? r_res[w_dr_row][w_dr_col] : '0;
    assign m_last      = m_valid && w_dr_last;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_tmo;
endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Randomized bench for tile_seq_ctrl against a tile-level reference model.
module tb_tile_seq_ctrl;
    import tile_seq_pkg::*;

    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CFG_W-1:0]  cfg_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    tile_t             dp_tile;
    logic [CFG_W-1:0]  dp_cfg;
    logic              dp_start;
    tile_t             dp_result = '0;
    logic              dp_done = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              err_len;
    logic              err_timeout;
    logic              err_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [CFG_W-1:0]  exp_cfg = '0;
    logic              exp_elen = 1'b0;
    logic              exp_etmo = 1'b0;
    logic [DATA_W-1:0] exp_tile [NELEM];
    logic [DATA_W-1:0] exp_res  [NELEM];

    always #5 clk = ~clk;

    tile_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .dp_tile(dp_tile), .dp_cfg(dp_cfg), .dp_start(dp_start),
        .dp_result(dp_result), .dp_done(dp_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tile_diff();
        int d = 0;
        for (int i = 0; i < NELEM; i++)
            if (dp_tile[i / COLS][i % COLS] !== exp_tile[i]) d++;
        return d;
    endfunction

    task automatic clr_err(input string nm);
        tick();
        @(negedge clk);
        chk({nm, "_elen_pre"}, err_len, exp_elen);
        chk({nm, "_etmo_pre"}, err_timeout, exp_etmo);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_elen = 1'b0;
        exp_etmo = 1'b0;
        @(negedge clk);
        chk({nm, "_elen_clr"}, err_len, exp_elen);
        chk({nm, "_etmo_clr"}, err_timeout, exp_etmo);
    endtask

    task automatic run_tile(input string nm, input int len, input bit seq, input bit cfg_first,
                            input logic [CFG_W-1:0] cfg, input bit gaps, input bit clr_last,
                            input bit early_done, input int delay, input bit rnd_ready,
                            input bit tmo, input int rst_at);
        logic [DATA_W-1:0] b [$];
        logic [DATA_W-1:0] hold_d;
        logic              hold_l, hold_v;
        int starts, early, n, j, cyc, bad, stall_bad, nomv;

        b = {};
        for (int i = 0; i < len; i++)
            b.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
        for (int i = 0; i < NELEM; i++)
            exp_tile[i] = (i < len) ? b[i] : 8'h00;
        exp_cfg = cfg;
        if (len != NELEM) exp_elen = 1'b1;

        tick();
        if (!cfg_first) begin
            cfg_valid = 1'b1;
            cfg_data  = cfg;
            tick();
            cfg_valid = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid   = 1'b1;
            s_data    = b[i];
            s_last    = (i == len - 1);
            err_clr   = clr_last && (i == len - 1);
            cfg_valid = (i == 0 && cfg_first) || (i == 3);
            cfg_data  = (i == 0) ? cfg : 16'hDEAD;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk({nm, "_sready_wait"}, 32'(n), 0);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; cfg_valid = 1'b0; err_clr = 1'b0;

        if (early_done) dp_done = 1'b1;
        @(negedge clk);
        chk({nm, "_start"}, dp_start, 1);
        chk({nm, "_cfg"}, dp_cfg, exp_cfg);
        chk({nm, "_tile"}, tile_diff(), 0);
        chk({nm, "_elen"}, err_len, exp_elen);
        chk({nm, "_sready_run"}, s_ready, 0);
        starts = 1;
        early  = 0;

        if (tmo) begin
            for (int c = 2; c <= TMO; c++) begin
                tick();
                dp_done = 1'b0;
                @(negedge clk);
                if (!busy || m_valid || err_timeout) early++;
                starts += dp_start;
            end
            tick();
            @(negedge clk);
            chk({nm, "_tmo_busy"}, busy, 0);
            chk({nm, "_tmo_flag"}, err_timeout, 1);
            chk({nm, "_tmo_mvalid"}, m_valid, 0);
            chk({nm, "_tmo_early"}, early, 0);
            chk({nm, "_starts"}, starts, 1);
            exp_etmo = 1'b1;
            return;
        end

        for (int i = 0; i < NELEM; i++) begin
            exp_res[i] = 8'($urandom_range(0, 255));
            dp_result[i / COLS][i % COLS] = exp_res[i];
        end
        for (int c = 1; c < delay; c++) begin
            tick();
            dp_done = 1'b0;
            @(negedge clk);
            starts += dp_start;
            if (m_valid || !busy) early++;
        end
        tick();
        dp_done = 1'b1;
        @(negedge clk);
        starts += dp_start;
        if (m_valid) early++;
        tick();
        dp_done = 1'b0;
        for (int i = 0; i < NELEM; i++)
            dp_result[i / COLS][i % COLS] = 8'($urandom_range(0, 255));
        @(negedge clk);
        chk({nm, "_mvalid_lat"}, m_valid, 1);
        chk({nm, "_starts"}, starts, 1);
        chk({nm, "_early"}, early, 0);

        j = 0; cyc = 0; bad = 0; stall_bad = 0; nomv = 0; hold_v = 1'b0;
        hold_d = '0; hold_l = 1'b0;
        while (j < NELEM && cyc < 4000) begin
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < NELEM; i++) exp_tile[i] = 8'h00;
                exp_cfg = '0; exp_elen = 1'b0; exp_etmo = 1'b0;
                chk({nm, "_rst_mvalid"}, m_valid, 0);
                chk({nm, "_rst_mdata"}, m_data, 0);
                chk({nm, "_rst_mlast"}, m_last, 0);
                chk({nm, "_rst_busy"}, busy, 0);
                chk({nm, "_rst_sready"}, s_ready, 0);
                chk({nm, "_rst_start"}, dp_start, 0);
                chk({nm, "_rst_cfg"}, dp_cfg, exp_cfg);
                chk({nm, "_rst_tile"}, tile_diff(), 0);
                chk({nm, "_rst_errs"}, {err_len, err_timeout}, 0);
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                m_ready = 1'b0;
                @(negedge clk);
                chk({nm, "_rst_sready_rel"}, s_ready, 1);
                return;
            end
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!m_valid) nomv++;
            if (hold_v && (m_data !== hold_d || m_last !== hold_l)) stall_bad++;
            if (m_valid && m_ready) begin
                if (m_data !== exp_res[j] || m_last !== (j == NELEM - 1)) bad++;
                j++;
                hold_v = 1'b0;
            end else if (m_valid) begin
                hold_v = 1'b1;
                hold_d = m_data;
                hold_l = m_last;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk({nm, "_drain_cnt"}, j, NELEM);
        chk({nm, "_drain_data"}, bad, 0);
        chk({nm, "_drain_stall"}, stall_bad, 0);
        chk({nm, "_drain_gap"}, nomv, 0);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_idle_sready"}, s_ready, 1);
        chk({nm, "_idle_mvalid"}, m_valid, 0);
        if (!rnd_ready) chk({nm, "_drain_cycles"}, cyc, NELEM);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NELEM; i++) exp_tile[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_start", dp_start, 0);
        chk("rst_cfg", dp_cfg, 0);
        chk("rst_tile", tile_diff(), 0);
        chk("rst_errs", {err_len, err_timeout}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_sready", s_ready, 1);

        run_tile("t1_full",  128, 1, 0, 16'h00A5, 0, 0, 0, 5, 0, 0, -1);
        run_tile("t2_short",  10, 0, 1, 16'h1234, 0, 1, 1, 3, 0, 0, -1);
        clr_err("c1");
        run_tile("t3_long",  140, 0, 0, 16'h0F0F, 1, 0, 0, 7, 0, 0, -1);
        run_tile("t4_stall", 128, 0, 0, 16'hBEEF, 1, 0, 0, 4, 1, 0, -1);
        clr_err("c2");
        run_tile("t5_tmo",   128, 0, 0, 16'h5555, 0, 0, 0, 0, 0, 1, -1);
        clr_err("c3");
        run_tile("t6_rst",   128, 0, 0, 16'h7777, 0, 0, 0, 6, 0, 0, 50);
        run_tile("t7_fresh", 128, 0, 1, 16'h3C3C, 1, 0, 0, 9, 1, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
